buff_drain_sched: RTL

Pop-side scheduler for the multi-FIFO static circular buffer. It mirrors the push stream to keep a shadow occupancy count per FIFO, and arbitrates among non-empty FIFOs. It issues at most one pop per cycle into the buffer and collects the fixed-latency pop data into a small credit-protected output queue with a valid/ready handshake. It sits between the buffer's pop port and the downstream consumer.

---
 rtl/buff_drain_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/buff_drain_sched.sv
// Pop-side scheduler for the multi-FIFO circular buffer: shadow counts, arbitration, credit-protected output queue.
// Define DRAIN_STRICT_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module buff_drain_sched #(
    parameter  int NUMELEM   = 4,
    parameter  int BITDATA   = 4,
    parameter  int NUMFIFO   = 8,
    parameter  int POP_DELAY = 2,
    localparam int BITELEM   = $clog2(NUMELEM),
    localparam int BITFIFO   = $clog2(NUMFIFO),
    localparam int QDEPTH    = POP_DELAY + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               buf_ready,
    input  logic               push,
    input  logic [BITFIFO-1:0] pu_prt,
    output logic               pop,
    output logic [BITFIFO-1:0] po_prt,
    input  logic [BITDATA-1:0] po_dout,
    output logic               out_vld,
    output logic [BITFIFO-1:0] out_prt,
    output logic [BITDATA-1:0] out_dat,
    input  logic               out_rdy,
    output logic               ovf_err
);
    localparam int BITCRD = $clog2(QDEPTH + 1);
    localparam int BITQP  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    localparam logic [BITELEM:0]   CNT_FULL = (BITELEM + 1)'(NUMELEM);
    localparam logic [BITCRD-1:0]  CRD_MAX  = BITCRD'(QDEPTH);
    localparam logic [BITQP-1:0]   QLAST    = BITQP'(QDEPTH - 1);

    logic [BITELEM:0]           cnt [NUMFIFO];
    logic [BITCRD-1:0]          crd;
    logic [POP_DELAY-1:0]       pipe_vld;
    logic [BITFIFO-1:0]         pipe_prt [POP_DELAY];
    logic [BITFIFO+BITDATA-1:0] q_mem [QDEPTH];
    logic [BITQP-1:0]           q_rd;
    logic [BITQP-1:0]           q_wr;
    logic [BITCRD-1:0]          q_cnt;
    logic                       any_nz;
    logic [BITFIFO-1:0]         grant;
    logic                       hs;
    logic                       q_push;
    logic                       push_ovf;

`ifdef DRAIN_STRICT_PRIO_EN
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        any_nz = 1'b0;
        grant  = '0;
        // Descending scan: the last hit, i.e. the lowest index, wins.
        for (int i = NUMFIFO - 1; i >= 0; i--) begin
            if (cnt[i] != '0) begin
                any_nz = 1'b1;
                grant  = BITFIFO'(i);
            end
        end
    end
`else
    localparam logic [BITFIFO-1:0] FLAST = BITFIFO'(NUMFIFO - 1);

    logic [BITFIFO-1:0] rr;
    int                 idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        any_nz = 1'b0;
        grant  = '0;
        idx    = 0;
        // Descending scan from rr: the last hit is the first non-empty FIFO at or after rr.
        for (int i = NUMFIFO - 1; i >= 0; i--) begin
            idx = int'(rr) + i;
            if (idx >= NUMFIFO) idx = idx - NUMFIFO;
            if (cnt[idx] != '0) begin
                any_nz = 1'b1;
                grant  = BITFIFO'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rr <= '0;
        end else if (pop) begin
            rr <= (grant == FLAST) ? '0 : grant + 1'b1;
        end
    end
`endif

    assign pop      = buf_ready && (crd != '0) && any_nz;
    assign po_prt   = grant;
    assign hs       = out_vld && out_rdy;
    assign q_push   = pipe_vld[POP_DELAY-1];
    assign push_ovf = push && (cnt[pu_prt] == CNT_FULL) && !(pop && (po_prt == pu_prt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < NUMFIFO; f++) cnt[f] <= '0;
            ovf_err <= 1'b0;
            crd     <= CRD_MAX;
        end else begin
            for (int f = 0; f < NUMFIFO; f++) begin
                if (push && (pu_prt == BITFIFO'(f)) && !(pop && (po_prt == BITFIFO'(f)))) begin
                    if (cnt[f] != CNT_FULL) cnt[f] <= cnt[f] + 1'b1;
                end else if (pop && (po_prt == BITFIFO'(f)) && !(push && (pu_prt == BITFIFO'(f)))) begin
                    cnt[f] <= cnt[f] - 1'b1;
                end
            end
            if (push_ovf) ovf_err <= 1'b1;
            if (pop && !hs)      crd <= crd - 1'b1;
            else if (hs && !pop) crd <= crd + 1'b1;
        end
    end

    // Return pipe tracks which FIFO each in-flight pop belongs to; reset drops late po_dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int k = 0; k < POP_DELAY; k++) pipe_prt[k] <= '0;
        end else begin
            pipe_vld[0] <= pop;
            pipe_prt[0] <= po_prt;
            for (int k = 1; k < POP_DELAY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_prt[k] <= pipe_prt[k-1];
            end
        end
    end

    assign out_vld            = (q_cnt != '0);
    assign {out_prt, out_dat} = q_mem[q_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the queue storage is reset (only QDEPTH entries) so the head reads zero out of reset.
            for (int k = 0; k < QDEPTH; k++) q_mem[k] <= '0;
            q_rd  <= '0;
            q_wr  <= '0;
            q_cnt <= '0;
        end else begin
            if (q_push) begin
                q_mem[q_wr] <= {pipe_prt[POP_DELAY-1], po_dout};
                q_wr        <= (q_wr == QLAST) ? '0 : q_wr + 1'b1;
            end
            if (hs) q_rd <= (q_rd == QLAST) ? '0 : q_rd + 1'b1;
            if (q_push && !hs)      q_cnt <= q_cnt + 1'b1;
            else if (hs && !q_push) q_cnt <= q_cnt - 1'b1;
        end
    end

    // Credits bound outstanding pops to QDEPTH, so a write into a full queue is a design error.
    a_no_q_overflow: assert property (@(posedge clk) disable iff (rst) !(q_push && (q_cnt == CRD_MAX)));

endmodule
